// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared definitions for the SPI RAM controller.
//   - Opcode constants carried in din[9:8] of each command word.
//   - Sequencer FSM state encoding.
package spi_ram_pkg;

    localparam logic [1:0] WR_ADDR = 2'b00;
    localparam logic [1:0] WR_DATA = 2'b01;
    localparam logic [1:0] RD_ADDR = 2'b10;
    localparam logic [1:0] RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StWrReady = 2'b01,
        StRdReady = 2'b10
    } state_e;

endpackage

// File: rtl/spi_ram_mem.sv
// spi_ram_mem: byte-wide RAM with one write port and one registered read port.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset; clears only the read register, never the array
//   we_i     - write enable
//   waddr_i  - write address (already reduced below MEM_DEPTH)
//   wdata_i  - write data
//   re_i     - read enable; rdata_o updates on the next rising edge
//   raddr_i  - read address (already reduced below MEM_DEPTH)
//   rdata_o  - registered read data, holds its value when re_i is low
module spi_ram_mem #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [ADDR_SIZE-1:0] waddr_i,
    input  logic [7:0]           wdata_i,
    input  logic                 re_i,
    input  logic [ADDR_SIZE-1:0] raddr_i,
    output logic [7:0]           rdata_o
);

    logic [7:0] mem_q [MEM_DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first: a same-cycle write to the read address is forwarded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command sequencer between an SPI slave and a byte-wide RAM.
// Each rising edge of rx_valid executes the command in din once:
//   00 WR_ADDR  set write address      01 WR_DATA  write byte, post-increment address
//   10 RD_ADDR  set read address       11 RD_DATA  read byte, pulse tx_valid next cycle
// Ports:
//   clk      - clock, rising edge
//   rst_n    - synchronous active-low reset (memory contents are kept)
//   din      - command word: [9:8] opcode, [7:0] payload
//   rx_valid - command valid, may be held high across many cycles
//   dout     - read data, holds between reads
//   tx_valid - one-cycle pulse marking fresh dout
//   err      - sticky sequencing error (only with SPI_RAM_ERR_EN)
// Build option SPI_RAM_ERR_EN: when defined, WR_DATA outside WR_READY and RD_DATA outside
// RD_READY are dropped and set err; when undefined they execute with the current address.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid
`ifdef SPI_RAM_ERR_EN
    ,
    output logic       err
`endif
);

    state_e               state_q;
    logic                 rx_q;
    logic [ADDR_SIZE-1:0] wr_addr_q;
    logic [ADDR_SIZE-1:0] rd_addr_q;
    logic                 tx_valid_q;
`ifdef SPI_RAM_ERR_EN
    logic                 err_q;
    logic                 cmd_illegal;
`endif

    logic                 cmd_edge;
    logic [1:0]           opcode;
    logic [ADDR_SIZE-1:0] addr_in;
    logic [ADDR_SIZE-1:0] wr_addr_next;
    logic                 wr_exec;
    logic                 rd_exec;

    // Reduce an address modulo MEM_DEPTH (a no-op when MEM_DEPTH == 2**ADDR_SIZE).
    function automatic logic [ADDR_SIZE-1:0] wrap_addr(input logic [ADDR_SIZE-1:0] a);
        return ADDR_SIZE'(32'(a) % MEM_DEPTH);
    endfunction

    always_comb begin
        // Gating with rst_n keeps reset dominant over any command, including the RAM write.
        cmd_edge     = rst_n && rx_valid && !rx_q;
        opcode       = din[9:8];
        addr_in      = wrap_addr(din[ADDR_SIZE-1:0]);
        wr_addr_next = (wr_addr_q == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0
                                                                : wr_addr_q + ADDR_SIZE'(1);
`ifdef SPI_RAM_ERR_EN
        wr_exec     = cmd_edge && (opcode == WR_DATA) && (state_q == StWrReady);
        rd_exec     = cmd_edge && (opcode == RD_DATA) && (state_q == StRdReady);
        cmd_illegal = cmd_edge && (((opcode == WR_DATA) && (state_q != StWrReady)) ||
                                   ((opcode == RD_DATA) && (state_q != StRdReady)));
`else
        wr_exec     = cmd_edge && (opcode == WR_DATA);
        rd_exec     = cmd_edge && (opcode == RD_DATA);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_q       <= 1'b0;
            state_q    <= StIdle;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef SPI_RAM_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            rx_q       <= rx_valid;
            tx_valid_q <= rd_exec;
            if (cmd_edge) begin
                unique case (opcode)
                    WR_ADDR: begin
                        wr_addr_q <= addr_in;
                        state_q   <= StWrReady;
                    end
                    WR_DATA: begin
                        if (wr_exec) wr_addr_q <= wr_addr_next;
                    end
                    RD_ADDR: begin
                        rd_addr_q <= addr_in;
                        state_q   <= StRdReady;
                    end
                    RD_DATA: begin
                        if (rd_exec) state_q <= StIdle;
                    end
                endcase
            end
`ifdef SPI_RAM_ERR_EN
            if (cmd_illegal) err_q <= 1'b1;
`endif
        end
    end

    spi_ram_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (wr_exec),
        .waddr_i (wr_addr_q),
        .wdata_i (din[7:0]),
        .re_i    (rd_exec),
        .raddr_i (rd_addr_q),
        .rdata_o (dout)
    );

    assign tx_valid = tx_valid_q;
`ifdef SPI_RAM_ERR_EN
    assign err = err_q;
`endif

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: randomized self-checking bench for spi_ram_ctrl.
// A command-level model (array memory, integer addresses, expected-read queue) predicts every
// read; a negedge monitor checks each tx_valid pulse, dout hold, and err when built with
// SPI_RAM_ERR_EN.
module tb_spi_ram_ctrl;

    localparam int DEPTH = 256;
    localparam logic [1:0] OP_WA = 2'b00;
    localparam logic [1:0] OP_WD = 2'b01;
    localparam logic [1:0] OP_RA = 2'b10;
    localparam logic [1:0] OP_RD = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = 10'h000;
    logic       rx_valid = 1'b0;
    logic [7:0] dout;
    logic       tx_valid;
`ifdef SPI_RAM_ERR_EN
    logic       err;
`endif

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid)
`ifdef SPI_RAM_ERR_EN
        ,
        .err      (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int tx_pulses = 0;
    bit mon_en = 1'b0;

    // Command-level reference model.
    logic [7:0] m_mem [DEPTH];
    int         m_wr;
    int         m_rd;
    int         m_state;  // 0 idle, 1 write-ready, 2 read-ready
    bit         m_err;
    logic [7:0] m_dout;
    logic [7:0] exp_q [$];

    function automatic void model_reset();
        m_wr = 0;
        m_rd = 0;
        m_state = 0;
        m_err = 1'b0;
        m_dout = 8'h00;
        exp_q.delete();
    endfunction

    function automatic void model_exec(input logic [1:0] op, input logic [7:0] pl);
        bit drop;
        case (op)
            OP_WA: begin
                m_wr = int'(pl) % DEPTH;
                m_state = 1;
            end
            OP_WD: begin
`ifdef SPI_RAM_ERR_EN
                drop = (m_state != 1);
`else
                drop = 1'b0;
`endif
                if (drop) m_err = 1'b1;
                else begin
                    m_mem[m_wr] = pl;
                    m_wr = (m_wr + 1) % DEPTH;
                end
            end
            OP_RA: begin
                m_rd = int'(pl) % DEPTH;
                m_state = 2;
            end
            default: begin
`ifdef SPI_RAM_ERR_EN
                drop = (m_state != 2);
`else
                drop = 1'b0;
`endif
                if (drop) m_err = 1'b1;
                else begin
                    exp_q.push_back(m_mem[m_rd]);
                    m_state = 0;
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (tx_valid === 1'b1) begin
                tx_pulses++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_tx got tx_valid=1 dout=%h required no pulse", dout);
                end else begin
                    m_dout = exp_q.pop_front();
                    if (dout !== m_dout) begin
                        failures++;
                        $display("FAIL read_data got dout=%h required %h", dout, m_dout);
                    end
                end
            end else if (tx_valid !== 1'b0 || dout !== m_dout) begin
                failures++;
                $display("FAIL idle_hold got tx_valid=%b dout=%h required 0/%h",
                         tx_valid, dout, m_dout);
            end
`ifdef SPI_RAM_ERR_EN
            checks++;
            if (err !== m_err) begin
                failures++;
                $display("FAIL err_flag got err=%b required %b", err, m_err);
            end
`endif
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic cmd_edge(input logic [1:0] op, input logic [7:0] pl);
        din = {op, pl};
        rx_valid = 1'b1;
        @(posedge clk);
        model_exec(op, pl);
        #1;
    endtask

    task automatic cmd_release();
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] pl, input int hold);
        cmd_edge(op, pl);
        repeat (hold - 1) begin
            @(posedge clk);
            #1;
        end
        cmd_release();
    endtask

    task automatic test_reset();
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        checks++;
        if (tx_valid !== 1'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got tx_valid=%b dout=%h required 0/00", tx_valid, dout);
        end
`ifdef SPI_RAM_ERR_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err got err=%b required 0", err);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_fill();
        send(OP_WA, 8'h00, 1);
        for (int i = 0; i < DEPTH; i++) send(OP_WD, 8'($urandom), 1);
    endtask

    task automatic test_basic();
        send(OP_WA, 8'h05, 1);
        send(OP_WD, 8'hA5, 1);
        send(OP_RA, 8'h05, 1);
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'hA5) begin
            failures++;
            $display("FAIL basic_read got tx_valid=%b dout=%h required 1/a5", tx_valid, dout);
        end
        cmd_release();
        checks++;
        if (tx_valid !== 1'b0 || dout !== 8'hA5) begin
            failures++;
            $display("FAIL basic_pulse_end got tx_valid=%b dout=%h required 0/a5",
                     tx_valid, dout);
        end
    endtask

    task automatic test_wrap();
        send(OP_WA, 8'hFF, 1);
        send(OP_WD, 8'h11, 1);
        send(OP_WD, 8'h22, 1);
        send(OP_RA, 8'hFF, 1);
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'h11) begin
            failures++;
            $display("FAIL wrap_mem255 got tx_valid=%b dout=%h required 1/11", tx_valid, dout);
        end
        cmd_release();
        send(OP_RA, 8'h00, 1);
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== 8'h22) begin
            failures++;
            $display("FAIL wrap_mem0 got tx_valid=%b dout=%h required 1/22", tx_valid, dout);
        end
        cmd_release();
    endtask

    task automatic test_held_read();
        int p0;
        send(OP_RA, 8'($urandom), 1);
        p0 = tx_pulses;
        send(OP_RD, 8'h00, 12);
        checks++;
        if (tx_pulses - p0 != 1) begin
            failures++;
            $display("FAIL held_read_pulses got %0d required 1", tx_pulses - p0);
        end
    endtask

    task automatic test_read_after_reset();
        test_reset();
        cmd_edge(OP_RD, 8'h00);
        checks++;
`ifdef SPI_RAM_ERR_EN
        if (err !== 1'b1 || tx_valid !== 1'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL early_read got err=%b tx_valid=%b dout=%h required 1/0/00",
                     err, tx_valid, dout);
        end
`else
        if (tx_valid !== 1'b1 || dout !== m_mem[0]) begin
            failures++;
            $display("FAIL early_read got tx_valid=%b dout=%h required 1/%h",
                     tx_valid, dout, m_mem[0]);
        end
`endif
        cmd_release();
        send(OP_RA, 8'h09, 1);
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== m_mem[9]) begin
            failures++;
            $display("FAIL read_after_err got tx_valid=%b dout=%h required 1/%h",
                     tx_valid, dout, m_mem[9]);
        end
        cmd_release();
    endtask

    task automatic test_double_read();
        test_reset();
        send(OP_RA, 8'h03, 1);
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== m_mem[3]) begin
            failures++;
            $display("FAIL first_read got tx_valid=%b dout=%h required 1/%h",
                     tx_valid, dout, m_mem[3]);
        end
        cmd_release();
        cmd_edge(OP_RD, 8'h00);
        checks++;
`ifdef SPI_RAM_ERR_EN
        if (err !== 1'b1 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL second_read got err=%b tx_valid=%b required 1/0", err, tx_valid);
        end
`else
        if (tx_valid !== 1'b1 || dout !== m_mem[3]) begin
            failures++;
            $display("FAIL second_read got tx_valid=%b dout=%h required 1/%h",
                     tx_valid, dout, m_mem[3]);
        end
`endif
        cmd_release();
    endtask

    task automatic test_reset_cancel();
        logic [7:0] a;
        logic [7:0] v;
        a = 8'($urandom);
        v = 8'($urandom);
        send(OP_WA, a, 1);
        send(OP_WD, v, 1);
        send(OP_RA, a, 1);
        cmd_edge(OP_RD, 8'h00);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        checks++;
        if (tx_valid !== 1'b0 || dout !== 8'h00) begin
            failures++;
            $display("FAIL reset_cancel got tx_valid=%b dout=%h required 0/00", tx_valid, dout);
        end
        rst_n = 1'b1;
        send(OP_RA, a, 1);
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== v) begin
            failures++;
            $display("FAIL mem_kept got tx_valid=%b dout=%h required 1/%h", tx_valid, dout, v);
        end
        cmd_release();
    endtask

    task automatic test_reset_rx_high();
        logic [7:0] a;
        a = 8'($urandom);
        din = {OP_RA, a};
        rx_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        model_exec(OP_RA, a);
        #1;
        cmd_release();
        cmd_edge(OP_RD, 8'h00);
        checks++;
        if (tx_valid !== 1'b1 || dout !== m_mem[a]) begin
            failures++;
            $display("FAIL rx_high_after_reset got tx_valid=%b dout=%h required 1/%h",
                     tx_valid, dout, m_mem[a]);
        end
        cmd_release();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(1, 3)));
        end
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        mon_en = 1'b1;
        test_fill();
        test_basic();
        test_wrap();
        test_held_read();
        test_read_after_reset();
        test_double_read();
        test_reset_cancel();
        test_reset_rx_high();
        test_random();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_tx got %0d reads without a pulse required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 Parameter MEM_DEPTH, default 256, is the number of 8-bit memory words.
REQ-002 Parameter ADDR_SIZE, default 8, is the address width used; it SHALL satisfy 2**ADDR_SIZE >= MEM_DEPTH and ADDR_SIZE <= 8.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 din  input  10  command word from the SPI slave rx_data: [9:8] opcode, [7:0] payload.
REQ-007 rx_valid  input  1  command valid; may be held high for many cycles per command.
REQ-008 dout  output  8  read data to the SPI slave tx_data.
REQ-009 tx_valid  output  1  dout valid, single-cycle pulse.
REQ-010 err  output  1  sticky sequencing error; present only when SPI_RAM_ERR_EN is defined.

Function
REQ-011 A command SHALL execute only on the rx_valid rising edge: rx_valid=1 this cycle and 0 the previous cycle; a held rx_valid executes once.
REQ-012 Opcode 00 (WR_ADDR): wr_addr <= din[ADDR_SIZE-1:0]; payload bits above ADDR_SIZE are ignored.
REQ-013 Opcode 01 (WR_DATA): mem[wr_addr] <= din[7:0], then wr_addr <= wr_addr+1, wrapping from MEM_DEPTH-1 to 0.
REQ-014 Opcode 10 (RD_ADDR): rd_addr <= din[ADDR_SIZE-1:0].
REQ-015 Opcode 11 (RD_DATA): dout <= mem[rd_addr] and tx_valid=1 exactly one cycle after the executing edge; the payload is ignored.
REQ-016 tx_valid SHALL be 0 in every other cycle, and dout SHALL hold its last value between reads.
REQ-017 An address at or above MEM_DEPTH SHALL wrap modulo MEM_DEPTH.
REQ-018 The sequencer FSM SHALL have the states IDLE, WR_READY and RD_READY.
REQ-019 From any state, WR_ADDR -> WR_READY and RD_ADDR -> RD_READY.
REQ-020 WR_DATA is legal only in WR_READY and stays in WR_READY, so burst writes are allowed.
REQ-021 RD_DATA is legal only in RD_READY and returns to IDLE, so each read needs a fresh RD_ADDR.
REQ-022 A WR_DATA to the same address as the previous cycle's write followed immediately by RD_DATA SHALL return the newly written value (write-first).

Reset
REQ-023 When rst_n=0 at a clock edge: state=IDLE, wr_addr=0, rd_addr=0, dout=0, tx_valid=0, err=0, and the edge-detect register=0.
REQ-024 Memory contents SHALL NOT be reset.
REQ-025 A reset asserted while tx_valid is pending SHALL cancel the pulse.
REQ-026 After reset, a rx_valid already high SHALL count as a rising edge.

Configuration
REQ-027 With macro SPI_RAM_ERR_EN defined, an illegal command (REQ-020/021) SHALL be dropped with no memory or address change and no tx_valid, the FSM state SHALL be unchanged, and err SHALL be set to 1 until reset.
REQ-028 With SPI_RAM_ERR_EN undefined, the err port is absent, WR_DATA and RD_DATA execute in any state using the current wr_addr/rd_addr, and the FSM transitions of REQ-020/021 still apply.

Structure
REQ-029 Package spi_ram_pkg SHALL hold the opcode constants (WR_ADDR, WR_DATA, RD_ADDR, RD_DATA) and the FSM state encoding.
REQ-030 Storage SHALL be sub-module spi_ram_mem: one write port and one synchronous read port, parameterised by MEM_DEPTH and ADDR_SIZE.
REQ-031 The sequencer, address registers and edge detect SHALL reside in spi_ram_ctrl.

Verification
REQ-032 Bench SHALL cover: din=0x005 (WR_ADDR 5), then 0x1A5 (WR_DATA A5), then 0x205 (RD_ADDR 5), then 0x300 (RD_DATA) -> dout=0xA5 with a 1-cycle tx_valid.
REQ-033 Bench SHALL cover: WR_ADDR 0xFF, then WR_DATA 0x11 and WR_DATA 0x22 -> mem[255]=0x11 and mem[0]=0x22 (wrap).
REQ-034 Bench SHALL cover: RD_DATA held with rx_valid=1 for 12 cycles -> exactly one tx_valid pulse.
REQ-035 Bench SHALL cover, with SPI_RAM_ERR_EN: RD_DATA straight after reset -> err=1, tx_valid stays 0, dout=0x00; a later legal RD_ADDR/RD_DATA still reads.
REQ-036 Bench SHALL cover: RD_ADDR 3, RD_DATA, then a second RD_DATA -> first read returns mem[3]; the second is illegal (err=1 with macro, or reads mem[3] again without it).
REQ-037 Bench SHALL cover: rst_n=0 in the cycle after an RD_DATA edge -> tx_valid=0, dout=0, and memory contents are preserved.
